i2c_codec_responder: RTL and testbench
======================================

// Module: i2c_codec_responder
// PURPOSE
//  I2C target (responder) modelling the write side of the WM8731 control port.
//  It oversamples SCL/SDA on the system clock and detects START/STOP. It matches
//  the 7-bit device address, ACKs each byte and decodes 2-byte WM8731 writes
//  (7-bit reg addr + 9-bit data) into a one-cycle register-write strobe.
//  Used as the far end of the codec-init I2C master in sim and FPGA loopback.
// PARAMETERS
//  DEV_ADDR  7'b0011010  7-bit device address (write byte 8'h34)
// PORTS
//  clk        in     1  system clock; every event below is synchronous to it
//  rst        in     1  asynchronous, active-low reset
//  I2C_SCLK   in     1  I2C clock from the master
//  I2C_SDAT   inout  1  open-drain data: driven 1'b0 when sda_oe, else 1'bz
//  reg_wen    out    1  one-cycle pulse: a complete register write was received
//  reg_addr   out    7  register address of the last write (held until next write)
//  reg_data   out    9  register data of the last write (held)
//  wr_count   out    8  count of completed writes, wraps 255->0
//  busy       out    1  high from START to STOP (transaction in progress)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, sda_oe=0 (SDAT released), reg_wen=0,
//   reg_addr=0, reg_data=0, wr_count=0, busy=0; synchronizers preset to 1.
//  Input sampling: 2-FF synchronizer on SCL and SDA, then a 1-FF edge detect.
//   Pin-to-event latency is 3 clk.
//  Timing: each SCL high and low phase must last >=4 clk. Shorter phases are
//   outside the spec; the bench must not drive them.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//   START in any state (repeated start included): go to ADDR, clear bit counter,
//    busy=1, release SDA.
//   STOP in any state: go to IDLE, busy=0, release SDA. Partial writes are dropped.
//  Data bits: sampled on the SCL rising edge, MSB first, into an 8-bit shift
//   register. SDA changes while SCL is high are START/STOP, never data.
//  States:
//   IDLE: wait for START.
//   ADDR: 8 bits. On the 8th SCL falling edge:
//    byte=={DEV_ADDR,1'b0} -> ACK, then BYTE1;
//    any other byte (incl. R/W=1) -> IGNORE, no ACK.
//   BYTE1: 8 bits (reg_addr[6:0], data[8]). On the 8th falling edge: ACK, then BYTE2.
//   BYTE2: 8 bits (data[7:0]). On the 8th falling edge: ACK and commit.
//    The next state is BYTE1, so a following byte pair is a new write (auto-increment).
//   IGNORE: SDA stays released until START or STOP.
//  ACK slot: sda_oe=1 from the SCL falling edge after bit 8 until the next SCL
//   falling edge (after the 9th clock). SDA is then released and the bit counter
//   is cleared.
//  Commit: reg_wen=1 for exactly 1 clk, at the same edge sda_oe rises for the
//   BYTE2 ACK. In that cycle reg_addr<=byte1[7:1], reg_data<={byte1[0],byte2},
//   and wr_count<=wr_count+1 (8-bit wrap).
//  Reset mid-transaction: immediate return to the reset values and SDA release.
//   The next START restarts decoding cleanly.
//  No clock stretching: SCL is never driven.
// TESTING
//  1 Reset, then START, 8'h34, 8'h08, 8'h15, STOP -> 3 ACKs (SDAT===0 in each
//    9th clock), one reg_wen with addr=7'h04, data=9'h015, wr_count=1, busy low after STOP.
//  2 START, 8'h36 (wrong addr), 2 bytes, STOP -> no ACK (SDAT===z on 9th clock),
//    no reg_wen, wr_count unchanged.
//  3 START, 8'h34, then 4 bytes 8'h1E,8'h00,8'h0E,8'h42, STOP -> 2 reg_wen:
//    (7'h0F,9'h000) then (7'h07,9'h042), wr_count +2.
//  4 START, 8'h34, 8'h0C, then repeated START, 8'h34, 8'h12, 8'h01, STOP ->
//    first partial write dropped, single reg_wen (7'h09, 9'h001).
//  5 Assert rst while sda_oe=1 during an ACK slot -> SDAT released the next cycle,
//    outputs at reset values; the following full write (scenario 1) succeeds.
//  6 Run 256 writes -> wr_count wraps to 0; reg_addr/reg_data hold the last write.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// Bus between the WM8731-style I2C responder and its environment: the incoming
// SCL line plus the decoded register-write outputs. SDA stays a plain inout port.
`timescale 1ns/1ps
interface i2c_codec_responder_if;
    logic       I2C_SCLK;
    logic       reg_wen;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic [7:0] wr_count;
    logic       busy;

    modport master (
        output I2C_SCLK,
        input  reg_wen,
        input  reg_addr,
        input  reg_data,
        input  wr_count,
        input  busy
    );

    modport slave (
        input  I2C_SCLK,
        output reg_wen,
        output reg_addr,
        output reg_data,
        output wr_count,
        output busy
    );
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port: oversamples SCL/SDA,
// ACKs its address and decodes 2-byte writes into a one-cycle register strobe.
`timescale 1ns/1ps
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
    input  logic                         clk,
    input  logic                         rst,
    inout  wire                          I2C_SDAT,
    i2c_codec_responder_if.slave         bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_BYTE1  = 3'd2;
    localparam logic [2:0] S_BYTE2  = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;

    logic       r_sclMeta;
    logic       r_sclSync;
    logic       r_sclPrev;
    logic       r_sdaMeta;
    logic       r_sdaSync;
    logic       r_sdaPrev;

    logic [2:0] r_state;
    logic [3:0] r_bitCnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_sdaOe;
    logic       r_busy;
    logic       r_regWen;
    logic [6:0] r_regAddr;
    logic [8:0] r_regData;
    logic [7:0] r_wrCount;

    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_start;
    logic       w_stop;
    logic       w_receiving;

    // Lines idle high on an I2C bus, so the synchronizers are preset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclMeta <= 1'b1;
            r_sclSync <= 1'b1;
            r_sclPrev <= 1'b1;
            r_sdaMeta <= 1'b1;
            r_sdaSync <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclMeta <= bus.I2C_SCLK;
            r_sclSync <= r_sclMeta;
            r_sclPrev <= r_sclSync;
            r_sdaMeta <= I2C_SDAT;
            r_sdaSync <= r_sdaMeta;
            r_sdaPrev <= r_sdaSync;
        end
    end

    assign w_sclRise   = r_sclSync & ~r_sclPrev;
    assign w_sclFall   = ~r_sclSync & r_sclPrev;
    assign w_start     = r_sclSync & r_sclPrev & r_sdaPrev & ~r_sdaSync;
    assign w_stop      = r_sclSync & r_sclPrev & ~r_sdaPrev & r_sdaSync;
    // The 9th (ACK) clock is not data: r_sdaOe or a full counter blocks shifting.
    assign w_receiving = ((r_state == S_ADDR) || (r_state == S_BYTE1) || (r_state == S_BYTE2))
                         && !r_sdaOe && (r_bitCnt < 4'd8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= 4'd0;
            r_shift   <= 8'd0;
            r_byte1   <= 8'd0;
            r_sdaOe   <= 1'b0;
            r_busy    <= 1'b0;
            r_regWen  <= 1'b0;
            r_regAddr <= 7'd0;
            r_regData <= 9'd0;
            r_wrCount <= 8'd0;
        end else begin
            r_regWen <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitCnt <= 4'd0;
                r_busy   <= 1'b1;
                r_sdaOe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_bitCnt <= 4'd0;
                r_busy   <= 1'b0;
                r_sdaOe  <= 1'b0;
            end else if (w_sclRise && w_receiving) begin
                r_shift  <= {r_shift[6:0], r_sdaSync};
                r_bitCnt <= r_bitCnt + 4'd1;
            end else if (w_sclFall) begin
                if (r_sdaOe) begin
                    r_sdaOe  <= 1'b0;
                    r_bitCnt <= 4'd0;
                end else if (r_bitCnt == 4'd8) begin
                    case (r_state)
                        S_ADDR: begin
                            if (r_shift == {DEV_ADDR, 1'b0}) begin
                                r_sdaOe <= 1'b1;
                                r_state <= S_BYTE1;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                        S_BYTE1: begin
                            r_byte1 <= r_shift;
                            r_sdaOe <= 1'b1;
                            r_state <= S_BYTE2;
                        end
                        S_BYTE2: begin
                            // Commit on the same edge the ACK starts; return to BYTE1 for auto-increment.
                            r_sdaOe   <= 1'b1;
                            r_state   <= S_BYTE1;
                            r_regWen  <= 1'b1;
                            r_regAddr <= r_byte1[7:1];
                            r_regData <= {r_byte1[0], r_shift};
                            r_wrCount <= r_wrCount + 8'd1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign I2C_SDAT     = r_sdaOe ? 1'b0 : 1'bz;
    assign bus.reg_wen  = r_regWen;
    assign bus.reg_addr = r_regAddr;
    assign bus.reg_data = r_regData;
    assign bus.wr_count = r_wrCount;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: a bit-banged I2C master drives table rows and
// random writes; a byte-level model predicts ACKs and decoded register writes.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

    localparam logic [6:0] DEV     = 7'h1A;
    localparam logic [7:0] DEVBYTE = {DEV, 1'b0};

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    typedef struct packed {
        logic [0:4][7:0] bytes;
        logic [2:0]      nBytes;
        logic            stopAtEnd;
        logic [0:4]      ackMask;
        logic [1:0]      nWr;
        logic [0:1][6:0] wrAddr;
        logic [0:1][8:0] wrData;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sdaLow;
    wire  I2C_SDAT;

    int errors = 0;
    int checks = 0;

    logic [7:0] txBytes[$];
    bit         expAcks[$];
    wr_t        obsQ[$];
    wr_t        expQ[$];
    int         expCount;
    logic [6:0] lastAddr;
    logic [8:0] lastData;
    vec_t       vecs[5];

    always #5 clk = ~clk;

    pullup (I2C_SDAT);
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

    i2c_codec_responder_if busIf();

    i2c_codec_responder #(.DEV_ADDR(DEV)) dut (
        .clk      (clk),
        .rst      (rst),
        .I2C_SDAT (I2C_SDAT),
        .bus      (busIf.slave)
    );

    always @(negedge clk) begin
        if (rst && busIf.reg_wen)
            obsQ.push_back(wr_t'({busIf.reg_addr, busIf.reg_data}));
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2cStart();
        sdaLow = 1'b0;
        waitClk(3);
        busIf.I2C_SCLK = 1'b1;
        waitClk(4);
        sdaLow = 1'b1;
        waitClk(4);
        busIf.I2C_SCLK = 1'b0;
        waitClk(1);
    endtask

    task automatic i2cStop();
        sdaLow = 1'b1;
        waitClk(3);
        busIf.I2C_SCLK = 1'b1;
        waitClk(4);
        sdaLow = 1'b0;
        waitClk(4);
    endtask

    task automatic sendBit(input logic b);
        sdaLow = ~b;
        waitClk(3);
        busIf.I2C_SCLK = 1'b1;
        waitClk(4);
        busIf.I2C_SCLK = 1'b0;
        waitClk(1);
    endtask

    task automatic ackSlot(input bit expAck, input string name);
        sdaLow = 1'b0;
        waitClk(3);
        busIf.I2C_SCLK = 1'b1;
        waitClk(2);
        checkOutput(name, 32'(I2C_SDAT), expAck ? 32'd0 : 32'd1);
        waitClk(2);
        busIf.I2C_SCLK = 1'b0;
        waitClk(1);
    endtask

    task automatic applyStimulus(input bit stopAtEnd, input string tag);
        i2cStart();
        checkOutput({tag, " busy after START"}, 32'(busIf.busy), 32'd1);
        foreach (txBytes[i]) begin
            for (int b = 7; b >= 0; b--) sendBit(txBytes[i][b]);
            ackSlot(expAcks[i], $sformatf("%s ack byte%0d", tag, i));
        end
        if (stopAtEnd) i2cStop();
    endtask

    task automatic checkTransaction(input bit stopped, input string tag);
        int n;
        waitClk(2);
        checkOutput({tag, " write count"}, 32'(obsQ.size()), 32'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s write%0d addr", tag, i), 32'(obsQ[i].addr), 32'(expQ[i].addr));
            checkOutput($sformatf("%s write%0d data", tag, i), 32'(obsQ[i].data), 32'(expQ[i].data));
        end
        obsQ.delete();
        expQ.delete();
        checkOutput({tag, " wr_count"}, 32'(busIf.wr_count), 32'(expCount % 256));
        checkOutput({tag, " reg_addr"}, 32'(busIf.reg_addr), 32'(lastAddr));
        checkOutput({tag, " reg_data"}, 32'(busIf.reg_data), 32'(lastData));
        checkOutput({tag, " busy"}, 32'(busIf.busy), stopped ? 32'd0 : 32'd1);
        checkOutput({tag, " reg_wen idle"}, 32'(busIf.reg_wen), 32'd0);
    endtask

    // Byte-level view: an addressed segment ACKs every byte, and each complete
    // byte pair after the address forms a 16-bit word {addr[6:0], data[8:0]}.
    function automatic void modelSegment();
        bit addressed;
        logic [15:0] word;
        expAcks.delete();
        addressed = (txBytes[0] == DEVBYTE);
        foreach (txBytes[i]) expAcks.push_back(addressed);
        if (addressed) begin
            for (int k = 1; k + 1 < txBytes.size(); k += 2) begin
                word = {txBytes[k], txBytes[k + 1]};
                expQ.push_back(wr_t'(word));
                lastAddr = word[15:9];
                lastData = word[8:0];
                expCount++;
            end
        end
    endfunction

    task automatic runRow(input int r);
        txBytes.delete();
        expAcks.delete();
        for (int i = 0; i < int'(vecs[r].nBytes); i++) begin
            txBytes.push_back(vecs[r].bytes[i]);
            expAcks.push_back(vecs[r].ackMask[i]);
        end
        for (int w = 0; w < int'(vecs[r].nWr); w++) begin
            expQ.push_back(wr_t'({vecs[r].wrAddr[w], vecs[r].wrData[w]}));
            lastAddr = vecs[r].wrAddr[w];
            lastData = vecs[r].wrData[w];
            expCount++;
        end
        applyStimulus(vecs[r].stopAtEnd, $sformatf("row%0d", r));
        checkTransaction(vecs[r].stopAtEnd, $sformatf("row%0d", r));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " SDAT released"}, 32'(I2C_SDAT), 32'd1);
        checkOutput({tag, " reg_wen"}, 32'(busIf.reg_wen), 32'd0);
        checkOutput({tag, " reg_addr"}, 32'(busIf.reg_addr), 32'd0);
        checkOutput({tag, " reg_data"}, 32'(busIf.reg_data), 32'd0);
        checkOutput({tag, " wr_count"}, 32'(busIf.wr_count), 32'd0);
        checkOutput({tag, " busy"}, 32'(busIf.busy), 32'd0);
    endtask

    task automatic clearModel();
        obsQ.delete();
        expQ.delete();
        expCount = 0;
        lastAddr = 7'd0;
        lastData = 9'd0;
    endtask

    initial begin
        vecs[0] = '{bytes: {8'h34, 8'h08, 8'h15, 8'h00, 8'h00}, nBytes: 3'd3, stopAtEnd: 1'b1,
                    ackMask: 5'b11100, nWr: 2'd1, wrAddr: {7'h04, 7'h00}, wrData: {9'h015, 9'h000}};
        vecs[1] = '{bytes: {8'h36, 8'hAA, 8'h55, 8'h00, 8'h00}, nBytes: 3'd3, stopAtEnd: 1'b1,
                    ackMask: 5'b00000, nWr: 2'd0, wrAddr: {7'h00, 7'h00}, wrData: {9'h000, 9'h000}};
        vecs[2] = '{bytes: {8'h34, 8'h1E, 8'h00, 8'h0E, 8'h42}, nBytes: 3'd5, stopAtEnd: 1'b1,
                    ackMask: 5'b11111, nWr: 2'd2, wrAddr: {7'h0F, 7'h07}, wrData: {9'h000, 9'h042}};
        vecs[3] = '{bytes: {8'h34, 8'h0C, 8'h00, 8'h00, 8'h00}, nBytes: 3'd2, stopAtEnd: 1'b0,
                    ackMask: 5'b11000, nWr: 2'd0, wrAddr: {7'h00, 7'h00}, wrData: {9'h000, 9'h000}};
        vecs[4] = '{bytes: {8'h34, 8'h12, 8'h01, 8'h00, 8'h00}, nBytes: 3'd3, stopAtEnd: 1'b1,
                    ackMask: 5'b11100, nWr: 2'd1, wrAddr: {7'h09, 7'h00}, wrData: {9'h001, 9'h000}};

        rst = 1'b0;
        sdaLow = 1'b0;
        busIf.I2C_SCLK = 1'b1;
        clearModel();
        waitClk(3);
        checkResetValues("reset");
        rst = 1'b1;
        waitClk(3);

        for (int r = 0; r < 5; r++) runRow(r);

        // Reset in the middle of an address ACK, then a clean write afterwards.
        i2cStart();
        for (int b = 7; b >= 0; b--) sendBit(DEVBYTE[b]);
        sdaLow = 1'b0;
        waitClk(3);
        checkOutput("midrst ack driven", 32'(I2C_SDAT), 32'd0);
        rst = 1'b0;
        waitClk(1);
        checkResetValues("midrst");
        clearModel();
        rst = 1'b1;
        waitClk(2);
        busIf.I2C_SCLK = 1'b1;
        waitClk(4);
        runRow(0);

        for (int t = 0; t < 20; t++) begin
            int n;
            int sel;
            txBytes.delete();
            sel = $urandom_range(0, 9);
            if (sel < 7)       txBytes.push_back(DEVBYTE);
            else if (sel == 7) txBytes.push_back(DEVBYTE | 8'h01);
            else               txBytes.push_back(8'($urandom));
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom));
            modelSegment();
            applyStimulus(1'b1, $sformatf("rand%0d", t));
            checkTransaction(1'b1, $sformatf("rand%0d", t));
        end

        // 256 auto-increment writes from zero wrap the counter back to 0.
        rst = 1'b0;
        waitClk(2);
        rst = 1'b1;
        clearModel();
        waitClk(2);
        txBytes.delete();
        txBytes.push_back(DEVBYTE);
        for (int i = 0; i < 512; i++) txBytes.push_back(8'($urandom));
        modelSegment();
        applyStimulus(1'b1, "wrap");
        checkTransaction(1'b1, "wrap");
        checkOutput("wrap wr_count zero", 32'(busIf.wr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
